// File: rtl/teknofest_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : teknofest_mem_pkg
// Purpose  : Shared types and helpers for the two-master main-RAM arbiter.
//            Provides the sequencer state encoding, default RAM window
//            constants and the RAM window decode function.
// Revision : 1.0 - initial release
// ============================================================================
package teknofest_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [31:0] RAM_BASE_ADDR_DEF = 32'h4000_0000;
  localparam logic [31:0] RAM_MASK_ADDR_DEF = 32'h000f_ffff;

  // An address belongs to RAM when the bits outside the offset mask match
  // the base address exactly.
  function automatic logic in_ram_window(
    input logic [31:0] addr,
    input logic [31:0] base = RAM_BASE_ADDR_DEF,
    input logic [31:0] mask = RAM_MASK_ADDR_DEF
  );
    return (addr & ~mask) == base;
  endfunction

endpackage : teknofest_mem_pkg
`default_nettype wire

// File: rtl/teknofest_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : teknofest_rr_arb2
// Purpose  : Combinational two-request round-robin picker. On a tie the
//            request that was not granted last time wins.
// Ports    : req_i[1:0]   - request lines (bit n = master n)
//            last_grant_i - index granted on the previous arbitration
//            gnt_valid_o  - at least one request present
//            gnt_idx_o    - index of the winning master
// Revision : 1.0 - initial release
// ============================================================================
module teknofest_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = 1'b0;
    case (req_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ~last_grant_i;
      default: gnt_idx_o = 1'b0;
    endcase
  end

endmodule : teknofest_rr_arb2
`default_nettype wire

// File: rtl/teknofest_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : teknofest_mem_arbiter
// Purpose  : Arbitrates two bus masters onto the single-port main RAM.
//            A granted in-window request holds the RAM signals for a fixed
//            RAM_DELAY-cycle window, then pulses the master's ready with
//            registered read data. Out-of-window requests complete in one
//            cycle with zero data and never strobe the RAM.
// Ports    : clk_i, rst_i (async, active-high)
//            m0_*/m1_*    - master request/response (valid/ready handshake)
//            ram_*        - RAM address/data/strobe/read-enable and rdata
//            grant_o      - master owning the current transaction
//            busy_o       - transaction in ACCESS or RESP
// Revision : 1.0 - initial release
// ============================================================================
module teknofest_mem_arbiter
  import teknofest_mem_pkg::*;
#(
  parameter int          RAM_DELAY     = 16,
  parameter logic [31:0] RAM_BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] RAM_MASK_ADDR = 32'h000f_ffff
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_valid_i,
  output logic        m0_ready_o,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_valid_i,
  output logic        m1_ready_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_wstrb_o,
  output logic        ram_rd_en_o,
  input  logic [31:0] ram_rdata_i,
  output logic        grant_o,
  output logic        busy_o
);

  localparam int             CNT_W    = (RAM_DELAY > 2) ? $clog2(RAM_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_DELAY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               gnt_valid;
  logic               gnt_idx;
  logic [31:0]        sel_addr;

  // Only sampled in IDLE; the ungranted master is ignored until then.
  teknofest_rr_arb2 u_arb (
    .req_i        ({m1_valid_i, m0_valid_i}),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx)
  );

  assign sel_addr = gnt_idx ? m1_addr_i : m0_addr_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;   // makes m0 the winner of the first tie
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant_d      = gnt_idx;
          last_grant_d = gnt_idx;
          addr_d       = sel_addr;
          wdata_d      = gnt_idx ? m1_wdata_i : m0_wdata_i;
          wstrb_d      = gnt_idx ? m1_wstrb_i : m0_wstrb_i;
          if (in_ram_window(sel_addr, RAM_BASE_ADDR, RAM_MASK_ADDR)) begin
            state_d = ACCESS;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RESP;
            rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Writes keep the previous read data in the response register.
          if (wstrb_q == 4'b0000) begin
            rdata_d = ram_rdata_i;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/data are always presented from the request register; only the
  // strobes qualify them, and those are confined to the ACCESS window.
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign ram_wstrb_o = (state_q == ACCESS) ? wstrb_q : 4'b0000;
  assign ram_rd_en_o = (state_q == ACCESS) && (wstrb_q == 4'b0000);

  assign m0_ready_o  = (state_q == RESP) && !grant_q;
  assign m1_ready_o  = (state_q == RESP) &&  grant_q;
  assign m0_rdata_o  = rdata_q;
  assign m1_rdata_o  = rdata_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != IDLE);

endmodule : teknofest_mem_arbiter
`default_nettype wire

// File: tb/tb_teknofest_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_teknofest_mem_arbiter
// Purpose  : Self-checking bench for teknofest_mem_arbiter. Expected
//            responses are queued when a request is driven and popped when
//            a ready pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_teknofest_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_valid_i = 1'b0, m1_valid_i = 1'b0;
  logic        m0_ready_o, m1_ready_o;
  logic [31:0] m0_addr_i = '0, m0_wdata_i = '0, m1_addr_i = '0, m1_wdata_i = '0;
  logic [3:0]  m0_wstrb_i = '0, m1_wstrb_i = '0;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i = '0;
  logic [3:0]  ram_wstrb_o;
  logic        ram_rd_en_o, grant_o, busy_o;

  typedef struct packed {
    logic        m;
    logic [7:0]  lat;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_rdata = '0;

  always #5 clk_i = ~clk_i;

  teknofest_mem_arbiter #(
    .RAM_DELAY     (16),
    .RAM_BASE_ADDR (32'h4000_0000),
    .RAM_MASK_ADDR (32'h000f_ffff)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .m0_valid_i  (m0_valid_i),
    .m0_ready_o  (m0_ready_o),
    .m0_addr_i   (m0_addr_i),
    .m0_wdata_i  (m0_wdata_i),
    .m0_wstrb_i  (m0_wstrb_i),
    .m0_rdata_o  (m0_rdata_o),
    .m1_valid_i  (m1_valid_i),
    .m1_ready_o  (m1_ready_o),
    .m1_addr_i   (m1_addr_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_wstrb_i  (m1_wstrb_i),
    .m1_rdata_o  (m1_rdata_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_wstrb_o (ram_wstrb_o),
    .ram_rd_en_o (ram_rd_en_o),
    .ram_rdata_i (ram_rdata_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit m, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (m) begin
      m1_valid_i = v; m1_addr_i = a; m1_wdata_i = d; m1_wstrb_i = s;
    end else begin
      m0_valid_i = v; m0_addr_i = a; m0_wdata_i = d; m0_wstrb_i = s;
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // One transaction from a single master. drop_at>0 releases valid after
  // that many clock edges to model a protocol violation.
  task automatic run_txn(input string tag, input bit m, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] ramval, input int drop_at);
    exp_t e;
    int   lat = 0, rd_cnt = 0, wr_cnt = 0, other = 0;
    bit   done = 1'b0;
    bit   inwin = (addr[31:20] == 12'h400);
    e.m     = m;
    e.lat   = inwin ? 8'd17 : 8'd1;
    e.rdata = !inwin ? 32'h0 : ((wstrb == 4'b0) ? ramval : model_rdata);
    model_rdata = e.rdata;
    sb.push_back(e);
    ram_rdata_i = ramval;
    drive(m, 1'b1, addr, wdata, wstrb);
    while (!done && lat < 40) begin
      cycle();
      lat++;
      if (drop_at == lat) drive(m, 1'b0, addr, wdata, wstrb);
      if (ram_rd_en_o && ram_addr_o == addr) rd_cnt++;
      if (ram_wstrb_o != 4'b0 && ram_wstrb_o == wstrb && ram_addr_o == addr &&
          ram_wdata_o == wdata) wr_cnt++;
      if (m ? m0_ready_o : m1_ready_o) other++;
      if (m ? m1_ready_o : m0_ready_o) done = 1'b1;
    end
    drive(m, 1'b0, 32'h0, 32'h0, 4'h0);
    check({tag, ".ready_seen"}, 32'(done), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".latency"}, 32'(lat), 32'(e.lat));
      check({tag, ".rdata"}, m ? m1_rdata_o : m0_rdata_o, e.rdata);
      check({tag, ".grant"}, 32'(grant_o), 32'(e.m));
    end
    check({tag, ".rd_en_cycles"}, 32'(rd_cnt), (inwin && wstrb == 4'b0) ? 32'd16 : 32'd0);
    check({tag, ".wstrb_cycles"}, 32'(wr_cnt), (inwin && wstrb != 4'b0) ? 32'd16 : 32'd0);
    check({tag, ".other_ready"}, 32'(other), 32'd0);
    cycle();
    check({tag, ".idle_after"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int   cyc, prev, got;
    exp_t e;

    // ---- reset state ----
    repeat (3) cycle();
    check("rst.m0_ready", 32'(m0_ready_o), 32'd0);
    check("rst.m1_ready", 32'(m1_ready_o), 32'd0);
    check("rst.ram_wstrb", 32'(ram_wstrb_o), 32'd0);
    check("rst.ram_rd_en", 32'(ram_rd_en_o), 32'd0);
    check("rst.ram_addr", ram_addr_o, 32'd0);
    check("rst.ram_wdata", ram_wdata_o, 32'd0);
    check("rst.rdata", m0_rdata_o, 32'd0);
    check("rst.grant", 32'(grant_o), 32'd0);
    check("rst.busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;
    cycle();
    check("idle.busy", 32'(busy_o), 32'd0);

    // ---- single-master traffic ----
    run_txn("m0_read", 1'b0, 32'h4000_0010, 32'h0, 4'b0000, 32'hDEAD_BEEF, 0);
    run_txn("m1_write", 1'b1, 32'h4000_0020, 32'h1234_5678, 4'b0011, 32'h5555_AAAA, 0);
    run_txn("m0_oow", 1'b0, 32'h3000_0000, 32'h0, 4'b0000, 32'h7777_7777, 0);
    run_txn("m0_drop", 1'b0, 32'h4000_0040, 32'h0, 4'b0000, 32'hCAFE_F00D, 3);
    run_txn("m1_after_drop", 1'b1, 32'h400F_FFFC, 32'h0, 4'b0000, 32'h0BAD_CAFE, 0);

    // ---- reset during ACCESS of an m0 write ----
    drive(1'b0, 1'b1, 32'h4000_0080, 32'hFFFF_0000, 4'b1111);
    repeat (5) cycle();
    check("mid.wstrb_before", 32'(ram_wstrb_o), 32'hF);
    rst_i = 1'b1;
    #1;
    check("mid.wstrb_async", 32'(ram_wstrb_o), 32'd0);
    check("mid.busy_async", 32'(busy_o), 32'd0);
    check("mid.addr_async", ram_addr_o, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    got = 0;
    cycle();
    rst_i = 1'b0;
    repeat (4) begin
      cycle();
      if (m0_ready_o) got++;
    end
    check("mid.no_ready", 32'(got), 32'd0);
    model_rdata = 32'h0;
    run_txn("m1_post_rst", 1'b1, 32'h4000_0100, 32'h0, 4'b0000, 32'h1357_9BDF, 0);

    // ---- round-robin from reset with both masters always requesting ----
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.m = 1'(i % 2); e.lat = 8'd18; e.rdata = 32'hA5A5_0000;
      sb.push_back(e);
    end
    ram_rdata_i = 32'hA5A5_0000;
    drive(1'b0, 1'b1, 32'h4000_0200, 32'h0, 4'b0000);
    drive(1'b1, 1'b1, 32'h4000_0300, 32'h0, 4'b0000);
    cyc = 0; prev = 0; got = 0;
    while (got < 4 && cyc < 200) begin
      cycle();
      cyc++;
      if (m0_ready_o || m1_ready_o) begin
        e = sb.pop_front();
        check($sformatf("rr.grant%0d", got), 32'(m1_ready_o), 32'(e.m));
        check($sformatf("rr.both%0d", got), 32'(m0_ready_o & m1_ready_o), 32'd0);
        check($sformatf("rr.rdata%0d", got), e.m ? m1_rdata_o : m0_rdata_o, e.rdata);
        check($sformatf("rr.spacing%0d", got), 32'(cyc - prev), (got == 0) ? 32'd17 : 32'd18);
        prev = cyc;
        got++;
      end
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    check("rr.completed", 32'(got), 32'd4);
    cycle();
    check("rr.idle_after", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_teknofest_mem_arbiter
`default_nettype wire

// File: doc/teknofest_mem_arbiter.md
Name: teknofest_mem_arbiter

Overview:
- Two-master arbiter and sequencer for the single-port main RAM. It sits between the core's iomem port (m0) and a second bus master (m1: DMA/loader) and the RAM's addr/wdata/wstrb/rd_en/rdata port.
- Grants one master at a time, round-robin. Holds the RAM signals for a fixed RAM_DELAY access window, then returns a one-cycle ready pulse with registered read data.
- Out-of-window requests are answered immediately with zero data and never touch RAM.

Parameters:
RAM_DELAY, 16, number of cycles RAM signals are held per access (min 2)
RAM_BASE_ADDR, 32'h4000_0000, base byte address of RAM window
RAM_MASK_ADDR, 32'h000f_ffff, offset mask of RAM window; in-window when (addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  asynchronous reset, active-high
m0_valid_i  in  1  master 0 request, held until m0_ready_o
m0_ready_o  out  1  master 0 completion pulse, one cycle
m0_addr_i  in  32  master 0 byte address
m0_wdata_i  in  32  master 0 write data
m0_wstrb_i  in  4  master 0 byte strobes; 0 = read
m0_rdata_o  out  32  read data, valid when m0_ready_o=1
m1_valid_i, m1_ready_o, m1_addr_i, m1_wdata_i, m1_wstrb_i, m1_rdata_o  same as m0, for master 1
ram_addr_o  out  32  byte address to RAM (RAM slices word bits)
ram_wdata_o  out  32  write data to RAM
ram_wstrb_o  out  4  byte write enables to RAM
ram_rd_en_o  out  1  read enable to RAM
ram_rdata_i  in  32  RAM read data
grant_o  out  1  index of master owning the current transaction
busy_o  out  1  high in ACCESS or RESP

Behaviour:
- Reset values: state IDLE; all ready outputs 0; ram_wstrb_o=0, ram_rd_en_o=0, ram_addr_o=0, ram_wdata_o=0; rdata register 0; grant_o=0; busy_o=0; last_grant=1, so m0 wins the first tie.
- States are IDLE, ACCESS and RESP.
- IDLE, cycle T:
  - With no valid, stay in IDLE.
  - If one master is valid, grant it. If both are valid, grant the master != last_grant.
  - Register the granted master's addr, wdata and wstrb, and update last_grant.
  - In-window request: go to ACCESS.
  - Out-of-window request: go to RESP with the rdata register cleared to 0 and no RAM strobe.
- ACCESS, cycles T+1 .. T+RAM_DELAY:
  - Down-counter of width $clog2(RAM_DELAY) is loaded with RAM_DELAY-1.
  - ram_addr_o and ram_wdata_o are driven from the registered request.
  - ram_wstrb_o = registered wstrb.
  - ram_rd_en_o = (wstrb==0).
  - All RAM outputs are held stable for the whole window.
  - When count==0: capture ram_rdata_i into the rdata register (reads only; writes leave it unchanged) and go to RESP.
- RESP, one cycle:
  - The granted master's ready=1.
  - Both mX_rdata_o are driven from the rdata register (only meaningful with ready).
  - RAM outputs are deasserted: wstrb=0, rd_en=0.
  - Next state is IDLE unconditionally.
- Latency from valid to ready: in-window = RAM_DELAY+1 cycles; out-of-window = 1 cycle.
- Throughput: a master's next request re-enters arbitration in the IDLE cycle after RESP. There is a minimum one idle cycle between transactions.
- Protocol violation: if the granted master drops valid mid-transaction, the transaction still completes and ready is still pulsed. The ungranted master's signals are ignored until IDLE.
- Reset asserted mid-ACCESS: outputs go to reset values immediately (asynchronous). A partial write may have landed in RAM; this is accepted. No ready pulse is issued.
- Writes with a partial wstrb pass through unmodified; byte merging is done by the RAM.

Decomposition:
- Package teknofest_mem_pkg holds:
  - state enum {IDLE, ACCESS, RESP}
  - RAM window constants
  - function in_ram_window(addr)
- Sub-module teknofest_rr_arb2: two-request round-robin picker with inputs req[1:0] and last_grant, outputs gnt_valid and gnt_idx. Purely combinational; last_grant is registered in the parent.

Test Plan:
- m0 reads 0x4000_0010, RAM returns 0xDEAD_BEEF → ram_rd_en_o high for exactly 16 cycles; m0_ready_o pulses at T+17; m0_rdata_o=0xDEAD_BEEF; m1_ready_o stays 0.
- m1 writes 0x4000_0020, wdata 0x1234_5678, wstrb 4'b0011 → ram_wstrb_o=4'b0011 for 16 cycles; ram_rd_en_o=0; m1_ready_o at T+17; grant_o=1.
- m0 and m1 both valid from reset, each holding valid again after completion → grant order m0, m1, m0, m1; each transaction is 18 cycles apart (RAM_DELAY+2).
- m0 reads 0x3000_0000 (out of window) → m0_ready_o at T+1; m0_rdata_o=0; ram_rd_en_o and ram_wstrb_o never assert.
- rst_i asserted at ACCESS cycle 5 of an m0 write → ram_wstrb_o=0 and busy_o=0 in the same cycle; no m0_ready_o pulse; after release, a new m1 request is served normally.
- m0 drops valid at ACCESS cycle 3 → ram signals stay held; m0_ready_o still pulses at T+17; the next request arbitrates normally.
